// File: rtl/midi_uart_tx_if.sv
// MIDI event handshake between an event source (master) and the serial framer (slave).
interface midi_uart_tx_if;
  logic       midi_event_valid;
  logic [7:0] midi_command;
  logic [6:0] midi_parameter_1;
  logic [6:0] midi_parameter_2;
  logic       midi_event_ack;

  modport master (
    output midi_event_valid,
    output midi_command,
    output midi_parameter_1,
    output midi_parameter_2,
    input  midi_event_ack
  );

  modport slave (
    input  midi_event_valid,
    input  midi_command,
    input  midi_parameter_1,
    input  midi_parameter_2,
    output midi_event_ack
  );
endinterface

// File: rtl/midi_uart_tx.sv
// MIDI transmit framer: one event per handshake, sent as 8N1 bytes with optional
// running-status compression of repeated channel status bytes.
module midi_uart_tx #(
  parameter int unsigned CLK_FREQ       = 16000000,
  parameter int unsigned BAUD           = 31250,
  parameter bit          RUNNING_STATUS = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  midi_uart_tx_if.slave  midi_ev,
  output logic           serial_tx,
  output logic           busy
);
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic [1:0]       r_nbytes;
  logic [7:0]       r_bytes [4];
  logic [7:0]       r_last_status;
  logic             r_ack;
  logic             r_busy;
  logic             r_tx;

  logic [1:0] w_len;
  logic       w_rs;
  logic [1:0] w_nbytes;
  logic [7:0] w_b0, w_b1, w_b2;
  logic [7:0] w_next_last;
  logic       w_bit_end;
  logic       w_more;
  logic       w_take;

  always_comb begin
    w_len = 2'd0;
    case (midi_ev.midi_command[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: w_len = 2'd3;
      4'hC, 4'hD:                   w_len = 2'd2;
      4'hF: begin
        case (midi_ev.midi_command[3:0])
          4'h1, 4'h3: w_len = 2'd2;
          4'h2:       w_len = 2'd3;
          default:    w_len = 2'd1;
        endcase
      end
      default: w_len = 2'd0;
    endcase

    w_rs = RUNNING_STATUS && midi_ev.midi_command[7] && (midi_ev.midi_command[7:4] != 4'hF)
           && (midi_ev.midi_command == r_last_status);

    if (w_rs) begin
      w_nbytes = w_len - 2'd1;
      w_b0     = {1'b0, midi_ev.midi_parameter_1};
      w_b1     = {1'b0, midi_ev.midi_parameter_2};
      w_b2     = {1'b0, midi_ev.midi_parameter_2};
    end else begin
      w_nbytes = w_len;
      w_b0     = midi_ev.midi_command;
      w_b1     = {1'b0, midi_ev.midi_parameter_1};
      w_b2     = {1'b0, midi_ev.midi_parameter_2};
    end

    // Realtime (F8-FF) leaves running status alone; system common cancels it.
    w_next_last = r_last_status;
    if (midi_ev.midi_command[7:4] == 4'hF) begin
      if (!midi_ev.midi_command[3]) w_next_last = 8'h00;
    end else if (midi_ev.midi_command[7]) begin
      w_next_last = midi_ev.midi_command;
    end
  end

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_more    = ({1'b0, r_byte_idx} + 3'd1) < {1'b0, r_nbytes};
  // Acceptance is also allowed in the final stop-bit cycle so queued events follow with no gap.
  assign w_take    = midi_ev.midi_event_valid && !r_ack &&
                     ((r_state == IDLE) || ((r_state == STOP) && w_bit_end && !w_more));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_byte_idx    <= '0;
      r_nbytes      <= '0;
      r_last_status <= '0;
      r_ack         <= 1'b0;
      r_busy        <= 1'b0;
      r_tx          <= 1'b1;
      for (int unsigned k = 0; k < 4; k++) r_bytes[k] <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end
        START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
            r_tx      <= r_bytes[r_byte_idx][0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_bytes[r_byte_idx][r_bit_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_more) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= START;
              r_tx       <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_take) begin
        r_bytes[0]    <= w_b0;
        r_bytes[1]    <= w_b1;
        r_bytes[2]    <= w_b2;
        r_nbytes      <= w_nbytes;
        r_byte_idx    <= '0;
        r_bit_idx     <= '0;
        r_cnt         <= '0;
        r_ack         <= 1'b1;
        r_busy        <= 1'b1;
        r_last_status <= w_next_last;
        if (w_nbytes != 2'd0) begin
          r_state <= START;
          r_tx    <= 1'b0;
        end else begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      end
    end
  end

  assign midi_ev.midi_event_ack = r_ack;
  assign serial_tx              = r_tx;
  assign busy                   = r_busy;
endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: event-level timeline model checked every cycle, a line
// decoder for byte-level literal checks, directed scenarios and random traffic.
module tb_midi_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  midi_uart_tx_if ifa ();
  midi_uart_tx_if ifb ();
  logic tx0, tx1, busy0, busy1;

  midi_uart_tx #(.CLK_FREQ(16), .BAUD(4), .RUNNING_STATUS(1'b1)) u_rs (
    .clk(clk), .rst(rst), .midi_ev(ifa), .serial_tx(tx0), .busy(busy0));
  midi_uart_tx #(.CLK_FREQ(16), .BAUD(4), .RUNNING_STATUS(1'b0)) u_nors (
    .clk(clk), .rst(rst), .midi_ev(ifb), .serial_tx(tx1), .busy(busy1));

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // model state: one timeline per instance
  logic [7:0]  m_last [2];
  int          m_left [2];
  int          m_t    [2];
  logic [29:0] m_bits [2];
  logic        m_ack  [2];
  logic        m_busy [2];
  logic        m_tx   [2];

  // monitors and line decoder
  int         busy_cnt [2];
  int         ack_cnt  [2];
  int         ack_cyc  [2];
  logic       rx_on    [2];
  int         rx_ph    [2];
  logic [7:0] rx_sh    [2];
  logic [7:0] rx_log   [2][512];
  int         rx_cnt   [2];

  function automatic logic get_tx(int i);    return (i == 0) ? tx0 : tx1; endfunction
  function automatic logic get_busy(int i);  return (i == 0) ? busy0 : busy1; endfunction
  function automatic logic get_ack(int i);   return (i == 0) ? ifa.midi_event_ack : ifb.midi_event_ack; endfunction
  function automatic logic get_valid(int i); return (i == 0) ? ifa.midi_event_valid : ifb.midi_event_valid; endfunction
  function automatic logic [7:0] get_cmd(int i); return (i == 0) ? ifa.midi_command : ifb.midi_command; endfunction
  function automatic logic [6:0] get_p1(int i);  return (i == 0) ? ifa.midi_parameter_1 : ifb.midi_parameter_1; endfunction
  function automatic logic [6:0] get_p2(int i);  return (i == 0) ? ifa.midi_parameter_2 : ifb.midi_parameter_2; endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, got, exp);
    end
  endtask

  // Whole-event frame from the MIDI rules: byte list, then 10 line bits per byte.
  task automatic model_frame(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b,
                             input logic [7:0] last, input bit rs,
                             output int n, output logic [29:0] fr, output logic [7:0] nl);
    int len;
    logic [7:0] by [3];
    if (!c[7])                        len = 0;
    else if (c >= 8'hF0)              len = (c == 8'hF2) ? 3 : ((c == 8'hF1 || c == 8'hF3) ? 2 : 1);
    else if (c >= 8'hC0 && c < 8'hE0) len = 2;
    else                              len = 3;
    nl = last;
    if (c >= 8'h80 && c < 8'hF0)      nl = c;
    else if (c >= 8'hF0 && c < 8'hF8) nl = 8'h00;
    by[0] = c;
    by[1] = {1'b0, a};
    by[2] = {1'b0, b};
    if (rs && c >= 8'h80 && c < 8'hF0 && c == last) begin
      len   = len - 1;
      by[0] = by[1];
      by[1] = by[2];
    end
    n  = len;
    fr = '1;
    for (int k = 0; k < n; k++) begin
      fr[10*k] = 1'b0;
      for (int j = 0; j < 8; j++) fr[10*k + 1 + j] = by[k][j];
      fr[10*k + 9] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_last[i] = 8'h00; m_left[i] = 0; m_t[i] = 0;
        m_ack[i] = 1'b0; m_busy[i] = 1'b0; m_tx[i] = 1'b1;
      end else begin
        logic acc;
        if (m_left[i] > 0) begin
          m_left[i]--;
          m_t[i]++;
        end
        acc = (m_left[i] == 0) && !m_ack[i] && get_valid(i);
        if (acc) begin
          int n;
          logic [29:0] fr;
          logic [7:0] nl;
          model_frame(get_cmd(i), get_p1(i), get_p2(i), m_last[i], (i == 0), n, fr, nl);
          m_last[i] = nl;
          m_bits[i] = fr;
          m_left[i] = 10 * n * CPB;
          m_t[i]    = 0;
        end
        m_ack[i]  = acc;
        m_busy[i] = acc || (m_left[i] > 0);
        m_tx[i]   = (m_left[i] > 0) ? m_bits[i][m_t[i] / CPB] : 1'b1;
      end
    end
  endtask

  task automatic check_step();
    for (int i = 0; i < 2; i++) begin
      chk((i == 0) ? "tx_rs" : "tx_nors", {31'd0, get_tx(i)}, {31'd0, m_tx[i]});
      chk((i == 0) ? "busy_rs" : "busy_nors", {31'd0, get_busy(i)}, {31'd0, m_busy[i]});
      chk((i == 0) ? "ack_rs" : "ack_nors", {31'd0, get_ack(i)}, {31'd0, m_ack[i]});
      if (get_busy(i)) busy_cnt[i]++;
      if (get_ack(i)) begin
        ack_cnt[i]++;
        ack_cyc[i] = cyc_n;
      end
    end
  endtask

  task automatic rx_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rx_on[i] = 1'b0;
      end else if (!rx_on[i]) begin
        if (get_tx(i) == 1'b0) begin
          rx_on[i] = 1'b1;
          rx_ph[i] = 0;
        end
      end else begin
        rx_ph[i]++;
        if (rx_ph[i] < 9*CPB && rx_ph[i] >= CPB + CPB/2 && ((rx_ph[i] - CPB/2) % CPB) == 0)
          rx_sh[i][(rx_ph[i] - CPB/2) / CPB - 1] = get_tx(i);
        if (rx_ph[i] == 9*CPB + CPB/2) begin
          chk("stop_bit", {31'd0, get_tx(i)}, 32'd1);
          rx_log[i][rx_cnt[i] % 512] = rx_sh[i];
          rx_cnt[i]++;
          rx_on[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_n++;
    check_step();
    rx_step();
  endtask

  task automatic present(input int i, input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    if (i == 0) begin
      ifa.midi_command = c; ifa.midi_parameter_1 = a; ifa.midi_parameter_2 = b; ifa.midi_event_valid = 1'b1;
    end else begin
      ifb.midi_command = c; ifb.midi_parameter_1 = a; ifb.midi_parameter_2 = b; ifb.midi_event_valid = 1'b1;
    end
  endtask

  task automatic drop(input int i);
    if (i == 0) ifa.midi_event_valid = 1'b0;
    else        ifb.midi_event_valid = 1'b0;
  endtask

  task automatic wait_ack(input int i);
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (get_ack(i)) return;
    end
    total++; bad++;
    $display("FAIL ack_timeout inst %0d at cycle %0d: got no ack expected ack", i, cyc_n);
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 400; n++) begin
      if (!get_busy(i)) return;
      cyc();
    end
    total++; bad++;
    $display("FAIL idle_timeout inst %0d at cycle %0d: got busy expected idle", i, cyc_n);
  endtask

  task automatic send(input int i, input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    present(i, c, a, b);
    wait_ack(i);
    drop(i);
    wait_idle(i);
    cyc();
  endtask

  initial begin
    int r0, b0, a0, t1, t2;
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; ack_cnt[i] = 0; ack_cyc[i] = 0; rx_on[i] = 1'b0;
      rx_ph[i] = 0; rx_cnt[i] = 0; rx_sh[i] = '0; m_last[i] = '0; m_left[i] = 0;
      m_t[i] = 0; m_bits[i] = '1; m_ack[i] = 1'b0; m_busy[i] = 1'b0; m_tx[i] = 1'b1;
    end
    ifa.midi_event_valid = 1'b0; ifa.midi_command = '0; ifa.midi_parameter_1 = '0; ifa.midi_parameter_2 = '0;
    ifb.midi_event_valid = 1'b0; ifb.midi_command = '0; ifb.midi_parameter_1 = '0; ifb.midi_parameter_2 = '0;

    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_tx", {31'd0, tx0}, 32'd1);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_ack", {31'd0, ifa.midi_event_ack}, 32'd0);
    rst = 1'b0;
    cyc();

    // note on, full frame
    r0 = rx_cnt[0]; b0 = busy_cnt[0]; a0 = ack_cnt[0];
    present(0, 8'h90, 7'h3C, 7'h64);
    wait_ack(0);
    chk("start_at_ack", {31'd0, tx0}, 32'd0);
    drop(0);
    wait_idle(0);
    cyc();
    chk("noteon_bytes", rx_cnt[0] - r0, 32'd3);
    chk("noteon_b0", {24'd0, rx_log[0][r0 % 512]}, 32'h90);
    chk("noteon_b1", {24'd0, rx_log[0][(r0 + 1) % 512]}, 32'h3C);
    chk("noteon_b2", {24'd0, rx_log[0][(r0 + 2) % 512]}, 32'h64);
    chk("noteon_busy_cycles", busy_cnt[0] - b0, 32'd120);
    chk("noteon_ack_cycles", ack_cnt[0] - a0, 32'd1);

    // running status
    r0 = rx_cnt[0];
    send(0, 8'h90, 7'h40, 7'h00);
    chk("rs_bytes", rx_cnt[0] - r0, 32'd2);
    chk("rs_b0", {24'd0, rx_log[0][r0 % 512]}, 32'h40);
    chk("rs_b1", {24'd0, rx_log[0][(r0 + 1) % 512]}, 32'h00);

    // realtime keeps running status
    r0 = rx_cnt[0];
    send(0, 8'hF8, 7'h00, 7'h00);
    chk("rt_bytes", rx_cnt[0] - r0, 32'd1);
    chk("rt_b0", {24'd0, rx_log[0][r0 % 512]}, 32'hF8);
    r0 = rx_cnt[0];
    send(0, 8'h90, 7'h3E, 7'h64);
    chk("rt_rs_bytes", rx_cnt[0] - r0, 32'd2);
    chk("rt_rs_b0", {24'd0, rx_log[0][r0 % 512]}, 32'h3E);

    // system common cancels running status
    r0 = rx_cnt[0];
    send(0, 8'hF6, 7'h00, 7'h00);
    chk("sc_bytes", rx_cnt[0] - r0, 32'd1);
    r0 = rx_cnt[0];
    send(0, 8'h90, 7'h3C, 7'h64);
    chk("sc_next_bytes", rx_cnt[0] - r0, 32'd3);
    chk("sc_next_b0", {24'd0, rx_log[0][r0 % 512]}, 32'h90);

    // program change
    r0 = rx_cnt[0];
    send(0, 8'hC5, 7'h12, 7'h55);
    chk("pc_bytes", rx_cnt[0] - r0, 32'd2);
    chk("pc_b0", {24'd0, rx_log[0][r0 % 512]}, 32'hC5);
    chk("pc_b1", {24'd0, rx_log[0][(r0 + 1) % 512]}, 32'h12);

    // invalid command
    r0 = rx_cnt[0]; b0 = busy_cnt[0]; a0 = ack_cnt[0];
    send(0, 8'h45, 7'h01, 7'h02);
    repeat (3) cyc();
    chk("inv_bytes", rx_cnt[0] - r0, 32'd0);
    chk("inv_busy_cycles", busy_cnt[0] - b0, 32'd1);
    chk("inv_ack_cycles", ack_cnt[0] - a0, 32'd1);

    // back-to-back queued events
    r0 = rx_cnt[0]; b0 = busy_cnt[0];
    present(0, 8'h90, 7'h3C, 7'h64);
    wait_ack(0);
    t1 = ack_cyc[0];
    present(0, 8'h80, 7'h11, 7'h22);
    wait_ack(0);
    t2 = ack_cyc[0];
    drop(0);
    wait_idle(0);
    cyc();
    chk("b2b_ack_gap", t2 - t1, 32'd120);
    chk("b2b_busy_cycles", busy_cnt[0] - b0, 32'd240);
    chk("b2b_bytes", rx_cnt[0] - r0, 32'd6);

    // reset mid-frame, with a valid event present during reset
    present(0, 8'h90, 7'h3C, 7'h64);
    wait_ack(0);
    repeat (13*CPB - 1) cyc();
    a0 = ack_cnt[0];
    rst = 1'b1;
    cyc();
    chk("midrst_tx", {31'd0, tx0}, 32'd1);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_ack", {31'd0, ifa.midi_event_ack}, 32'd0);
    chk("midrst_no_ack", ack_cnt[0] - a0, 32'd0);
    rst = 1'b0;
    r0 = rx_cnt[0];
    wait_ack(0);
    drop(0);
    wait_idle(0);
    cyc();
    chk("postrst_bytes", rx_cnt[0] - r0, 32'd3);
    chk("postrst_b0", {24'd0, rx_log[0][r0 % 512]}, 32'h90);

    // running status disabled
    r0 = rx_cnt[1];
    send(1, 8'h90, 7'h3C, 7'h64);
    send(1, 8'h90, 7'h40, 7'h00);
    chk("nors_bytes", rx_cnt[1] - r0, 32'd6);
    chk("nors_b3", {24'd0, rx_log[1][(r0 + 3) % 512]}, 32'h90);

    // random traffic, checked cycle by cycle against the model
    for (int e = 0; e < 80; e++) begin
      logic [7:0] c;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: c = {4'h9, 3'd0, 1'($urandom_range(0, 1))};
        3:       c = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 15))};
        4:       c = {4'($urandom_range(12, 13)), 4'($urandom_range(0, 1))};
        5:       c = {4'hF, 4'($urandom_range(1, 3))};
        6:       c = {4'hF, 4'($urandom_range(8, 15))};
        7:       c = {4'hF, 1'b0, 3'($urandom_range(0, 7))};
        8:       c = {1'b0, 7'($urandom_range(0, 127))};
        default: c = 8'hB0;
      endcase
      present(0, c, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      wait_ack(0);
      if ($urandom_range(0, 1) == 0) begin
        drop(0);
        repeat ($urandom_range(0, 15)) cyc();
      end
    end
    drop(0);
    wait_idle(0);
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

Transmit-side MIDI framer: accepts one MIDI event per handshake, emits its status and data bytes as 8N1 serial at MIDI baud on `serial_tx`, with optional running-status compression. Mirror of the receive path's `midi_uart` framer. Sits between an event source (sequencer, arpeggiator, controller mapper) and the board's MIDI OUT pin, so a synth build can echo, thru or generate MIDI.

## Interface

- `CLK_FREQ`, 16000000: system clock frequency in Hz.
- `BAUD`, 31250: serial bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (512 at defaults); benches may override to small values.
- `RUNNING_STATUS`, 1: 1 = omit the status byte when it repeats the last sent channel status; 0 = always send it.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `midi_event_valid`  input  1  event present; the source holds it and all fields stable until ack.
- `midi_command`  input  8  status byte.
- `midi_parameter_1`  input  7  first data byte.
- `midi_parameter_2`  input  7  second data byte.
- `midi_event_ack`  output  1  one-cycle pulse; event latched.
- `serial_tx`  output  1  UART line, idle high.
- `busy`  output  1  high from the acceptance edge until the last stop bit completes.

## Operation

- Reset values: `serial_tx`=1, `midi_event_ack`=0, `busy`=0, `last_status`=0x00, FSM=IDLE.
- Acceptance happens when FSM=IDLE, `midi_event_valid`=1 and `midi_event_ack`=0.
  - On that edge the block latches the command and both parameters and sets `midi_event_ack`=1 for exactly one cycle.
  - It also computes the byte count and sets `busy`=1.
- Byte count by `midi_command`:
  - 8x, 9x, Ax, Bx, Ex: 3 bytes.
  - Cx, Dx, F1, F3: 2 bytes.
  - F2: 3 bytes.
  - F0, F4–F7, F8–FF: 1 byte (status only).
- Command with bit7=0 is invalid. It is acked, no bytes are sent, `busy` drops the next cycle and `last_status` is unchanged.
- Running status applies when `RUNNING_STATUS`=1, the command is 80–EF and it equals `last_status`. The status byte is skipped and only the data bytes are sent.
- `last_status` update rules:
  - 80–EF: set to the command on acceptance.
  - F0–F7: cleared to 0x00.
  - F8–FF (realtime): unchanged.
- Data bytes are sent as {1'b0, parameter[6:0]}.
- Bit FSM: IDLE → START (line 0) → DATA (8 bits, LSB first) → STOP (line 1) → LOAD.
  - LOAD goes to START if bytes remain.
  - Otherwise LOAD goes to IDLE.
- Bit-period counter runs 0..CLKS_PER_BIT-1. A bit index (0–7) and a byte index (0–2) select the current bit and byte.

## Timing

- Acceptance edge E: ack is high during cycle E+1. `serial_tx` falls at E+1; that is the first start-bit cycle.
- Every bit, including start and stop, is exactly CLKS_PER_BIT cycles.
- Consecutive bytes of one event have no idle gap: the next start bit follows the stop bit directly. LOAD is folded into the last stop-bit cycle.
- An N-byte event occupies 10·N·CLKS_PER_BIT cycles, starting at E+1.
- `busy` falls on the cycle after the final stop bit ends, and FSM=IDLE in that same cycle.
  - The next event can be accepted in that cycle, so back-to-back events have zero idle bit-time.
- `midi_event_valid` asserted while busy is held off; ack does not rise until IDLE.
- `rst` mid-frame: next cycle `serial_tx`=1, FSM=IDLE, counters and `last_status` cleared, no ack. A truncated byte is acceptable on the line.
- `rst` in the same cycle as a valid event: reset wins and there is no ack.

## Test plan

- Note on, CLKS_PER_BIT=4, event 0x90/0x3C/0x64:
  - Ack is a single pulse at E+1.
  - Line carries 0x90, 0x3C, 0x64 LSB first, each framed 0-bit…1-bit.
  - 120 cycles total, then `busy`=0.
- Running status with `RUNNING_STATUS`=1:
  - 0x90/3C/64 then 0x90/40/00 sends 5 bytes; the second event carries only 0x40, 0x00.
  - With `RUNNING_STATUS`=0, the same two events send 6 bytes.
- Realtime vs common message after 0x90/3C/64:
  - Sending 0xF8 emits 1 byte; a following 0x90/3E/64 still omits status.
  - Sending 0xF6 instead emits 1 byte; the next 0x90 event includes status.
- Program change 0xC5/0x12: exactly 2 bytes, 0xC5 then 0x12. Invalid command 0x45: ack, line stays high, `busy` high for one cycle.
- Back-to-back handshake, with `midi_event_valid` held high for two queued events:
  - Second ack occurs exactly at the cycle `busy` would drop.
  - No idle high period longer than the stop bit between events.
- Reset after 13 bit-times of a 3-byte event: `serial_tx`=1 and `busy`=0 the next cycle. A subsequent 0x90 event sends its status byte (last_status cleared).
